// File: rtl/vcm_af_pkg.sv
// Shared definitions for the contrast-autofocus sweep controller: state encoding
// and the layout of the 16-bit word handed to the VCM I2C writer.
package vcm_af_pkg;

    localparam int POS_LSB = 4;
    localparam int POS_W   = 10;
    localparam int SLEW_W  = 4;
    localparam int DATA_W  = 16;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_DRIVE   = 4'd1,
        S_TRIG    = 4'd2,
        S_SETTLE  = 4'd3,
        S_WAITS   = 4'd4,
        S_CMP     = 4'd5,
        S_FDRIVE  = 4'd6,
        S_FTRIG   = 4'd7,
        S_FSETTLE = 4'd8
    } state_t;

    function automatic logic [DATA_W-1:0] vcm_word(input logic [POS_W-1:0] pos,
                                                   input logic [SLEW_W-1:0] slew);
        return {2'b00, pos, slew};
    endfunction

endpackage

// File: rtl/vcm_af_timer.sv
// Loadable 32-bit down-counter; it stops at zero and flags it. It times both the
// trigger-high window and the mechanical settle window.
module vcm_af_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        zero
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign zero = (count == 32'd0);

endmodule

// File: rtl/vcm_focus_sweep.sv
// Contrast-autofocus sweep: steps the lens code, triggers the VCM writer, waits
// for settle, scores two frames later, then parks the lens at the sharpest code.
module vcm_focus_sweep
    import vcm_af_pkg::*;
#(
    parameter logic [9:0]  POS_START   = 10'd0,
    parameter logic [9:0]  POS_END     = 10'd1023,
    parameter logic [9:0]  POS_STEP    = 10'd32,
    parameter logic [3:0]  SLEW        = 4'h0,
    parameter logic [15:0] TR_HIGH_CYC = 16'd256,
    parameter logic [31:0] SETTLE_CYC  = 32'd500000
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        ABORT,
    input  logic        SHARP_VALID,
    input  logic [31:0] SHARP_VALUE,
    output logic [15:0] VCM_DATA,
    output logic        TR_OUT,
    output logic        BUSY,
    output logic        DONE,
    output logic [9:0]  BEST_POS,
    output logic [31:0] BEST_SHARP
);

    // Timer holds N-1 so a window spans exactly N cycles; zero-length windows collapse to one.
    localparam logic [31:0] TRIG_LOAD   = (TR_HIGH_CYC == 16'd0) ? 32'd0 : {16'd0, TR_HIGH_CYC} - 32'd1;
    localparam logic [31:0] SETTLE_LOAD = (SETTLE_CYC == 32'd0) ? 32'd0 : SETTLE_CYC - 32'd1;

    state_t      state;
    logic [9:0]  pos;
    logic [9:0]  best_pos_r;
    logic [31:0] best_sharp_r;
    logic [31:0] score;
    logic        frame_seen;
    logic [10:0] nxt;
    logic        timer_load;
    logic [31:0] timer_val;
    logic        timer_zero;

    assign nxt = {1'b0, pos} + {1'b0, POS_STEP};

    always_comb begin
        timer_load = 1'b0;
        timer_val  = 32'd0;
        if (state == S_TRIG || state == S_FTRIG) begin
            if (!TR_OUT) begin
                timer_load = 1'b1;
                timer_val  = TRIG_LOAD;
            end else if (timer_zero) begin
                timer_load = 1'b1;
                timer_val  = SETTLE_LOAD;
            end
        end
    end

    vcm_af_timer u_timer (
        .clk      (CLK_50),
        .rst_n    (RESET_N),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // SHARP_VALID is a one-cycle strobe with no back-pressure: a frame is consumed
    // only in WAITS (first dropped, second scored) and silently dropped elsewhere.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            pos          <= POS_START;
            best_pos_r   <= POS_START;
            best_sharp_r <= 32'd0;
            score        <= 32'd0;
            frame_seen   <= 1'b0;
            VCM_DATA     <= vcm_word(POS_START, SLEW);
            TR_OUT       <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            BEST_POS     <= 10'd0;
            BEST_SHARP   <= 32'd0;
        end else begin
            DONE <= 1'b0;
            if (ABORT && state != S_IDLE) begin
                state  <= S_IDLE;
                TR_OUT <= 1'b0;
                BUSY   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START && !ABORT) begin
                            pos          <= POS_START;
                            best_pos_r   <= POS_START;
                            best_sharp_r <= 32'd0;
                            BUSY         <= 1'b1;
                            state        <= S_DRIVE;
                        end
                    end
                    S_DRIVE: begin
                        VCM_DATA <= vcm_word(pos, SLEW);
                        state    <= S_TRIG;
                    end
                    S_TRIG, S_FTRIG: begin
                        if (!TR_OUT) begin
                            TR_OUT <= 1'b1;
                        end else if (timer_zero) begin
                            TR_OUT <= 1'b0;
                            state  <= (state == S_TRIG) ? S_SETTLE : S_FSETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (timer_zero) begin
                            frame_seen <= 1'b0;
                            state      <= S_WAITS;
                        end
                    end
                    S_WAITS: begin
                        if (SHARP_VALID) begin
                            if (frame_seen) begin
                                score <= SHARP_VALUE;
                                state <= S_CMP;
                            end else begin
                                frame_seen <= 1'b1;
                            end
                        end
                    end
                    S_CMP: begin
                        // best_pos_r already holds the first code, so a zero first score still wins.
                        if (score > best_sharp_r) begin
                            best_sharp_r <= score;
                            best_pos_r   <= pos;
                        end
                        if (pos == POS_END) begin
                            state <= S_FDRIVE;
                        end else begin
                            pos   <= (nxt > {1'b0, POS_END}) ? POS_END : nxt[9:0];
                            state <= S_DRIVE;
                        end
                    end
                    S_FDRIVE: begin
                        VCM_DATA <= vcm_word(best_pos_r, SLEW);
                        state    <= S_FTRIG;
                    end
                    S_FSETTLE: begin
                        if (timer_zero) begin
                            BEST_POS   <= best_pos_r;
                            BEST_SHARP <= best_sharp_r;
                            DONE       <= 1'b1;
                            BUSY       <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
